// File: rtl/wb_arbiter_if.sv
// Bundle of the writeback arbiter's ALU, load, scoreboard-query and register-file write signals.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline's view.
interface wb_arbiter_if #(
   parameter int N = 32,
   parameter int M = 5
);
   logic         alu_valid;
   logic [M-1:0] alu_rd;
   logic [N-1:0] alu_data;
   logic         alu_ready;
   logic         ld_issue;
   logic [M-1:0] ld_issue_rd;
   logic         ld_valid;
   logic [M-1:0] ld_rd;
   logic [N-1:0] ld_data;
   logic [M-1:0] rs1;
   logic [M-1:0] rs2;
   logic         hazard;
   logic         rf_we;
   logic [M-1:0] rf_adrs_w;
   logic [N-1:0] rf_data_w;

   modport slave (
      input  alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
      input  ld_valid, ld_rd, ld_data, rs1, rs2,
      output alu_ready, hazard, rf_we, rf_adrs_w, rf_data_w
   );

   modport master (
      output alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd,
      output ld_valid, ld_rd, ld_data, rs1, rs2,
      input  alu_ready, hazard, rf_we, rf_adrs_w, rf_data_w
   );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: load returns take the register-file port first, then the buffered ALU results.
// Also keeps a per-register load scoreboard. Define WB_BYPASS_EN to let ALU results skip an empty FIFO.
module wb_arbiter #(
   parameter int N     = 32,
   parameter int M     = 5,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input logic          clk,
   input logic          rst,
   wb_arbiter_if.slave  wb
);
   localparam int         NREG     = 2 ** M;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [M-1:0]    rd_mem_q   [DEPTH];
   logic [N-1:0]    data_mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q;
   logic [NREG-1:0] busy_q, busy_d;
   logic            rf_we_q, rf_we_d;
   logic [M-1:0]    rf_adrs_q, rf_adrs_d;
   logic [N-1:0]    rf_data_q, rf_data_d;
   logic [NREG-1:0] fifo_pend, ld_pend, pend;
   logic            fifo_empty, push, pop, bypass;

   assign fifo_empty   = (count_q == '0);
   assign wb.alu_ready = (count_q != FULL_CNT);

`ifdef WB_BYPASS_EN
   assign bypass = fifo_empty & ~wb.ld_valid & wb.alu_valid;
`else
   assign bypass = 1'b0;
`endif

   assign push = wb.alu_valid & wb.alu_ready & ~bypass;
   // Loads are never stalled, so the FIFO drains only in cycles without a load return.
   assign pop  = ~wb.ld_valid & ~fifo_empty;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves a latch behind.
      rf_we_d   = 1'b0;
      rf_adrs_d = rf_adrs_q;
      rf_data_d = rf_data_q;
      if (wb.ld_valid) begin
         rf_we_d   = (wb.ld_rd != '0);
         rf_adrs_d = wb.ld_rd;
         rf_data_d = wb.ld_data;
      end else if (pop) begin
         rf_we_d   = (rd_mem_q[rd_ptr_q] != '0);
         rf_adrs_d = rd_mem_q[rd_ptr_q];
         rf_data_d = data_mem_q[rd_ptr_q];
      end else if (bypass) begin
         rf_we_d   = (wb.alu_rd != '0);
         rf_adrs_d = wb.alu_rd;
         rf_data_d = wb.alu_data;
      end
   end

   always_comb begin
      busy_d = busy_q;
      if (wb.ld_valid) busy_d[wb.ld_rd] = 1'b0;
      if (wb.ld_issue) busy_d[wb.ld_issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      logic [AW-1:0] idx;
      fifo_pend = '0;
      idx       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr_q + AW'(k);
         if (k < int'(count_q)) fifo_pend[rd_mem_q[idx]] = 1'b1;
      end
   end

   always_comb begin
      ld_pend = '0;
      ld_pend[wb.ld_rd] = wb.ld_valid;
   end

   assign pend      = busy_q | fifo_pend | ld_pend;
   assign wb.hazard = ((wb.rs1 != '0) & pend[wb.rs1]) | ((wb.rs2 != '0) & pend[wb.rs2]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         busy_q    <= '0;
         rf_we_q   <= 1'b0;
         rf_adrs_q <= '0;
         rf_data_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + (AW + 1)'(1);
            2'b01:   count_q <= count_q - (AW + 1)'(1);
            default: count_q <= count_q;
         endcase
         busy_q    <= busy_d;
         rf_we_q   <= rf_we_d;
         rf_adrs_q <= rf_adrs_d;
         rf_data_q <= rf_data_d;
      end
   end

   // NOTE: FIFO storage is not reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         rd_mem_q[wr_ptr_q]   <= wb.alu_rd;
         data_mem_q[wr_ptr_q] <= wb.alu_data;
      end
   end

   assign wb.rf_we     = rf_we_q;
   assign wb.rf_adrs_w = rf_adrs_q;
   assign wb.rf_data_w = rf_data_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected register-file writes go into a queue that a negedge monitor
// drains whenever rf_we is seen; handshake, latency and hazard values are checked inline.
module tb_wb_arbiter;
   localparam int N = 32;
   localparam int M = 5;

`ifdef WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [M-1:0] rd;
      logic [N-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   wr_t  exp_q [$];

   always #5 clk = ~clk;

   wb_arbiter_if #(.N(N), .M(M)) wb ();

   wb_arbiter #(.N(N), .M(M), .DEPTH(4), .AW(2)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (wb)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_wr(input logic [M-1:0] rd, input logic [N-1:0] data);
      wr_t w;
      w.rd   = rd;
      w.data = data;
      exp_q.push_back(w);
   endtask

   task automatic clear_in();
      wb.alu_valid   = 1'b0;
      wb.alu_rd      = '0;
      wb.alu_data    = '0;
      wb.ld_issue    = 1'b0;
      wb.ld_issue_rd = '0;
      wb.ld_valid    = 1'b0;
      wb.ld_rd       = '0;
      wb.ld_data     = '0;
      wb.rs1         = '0;
      wb.rs2         = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every rf_we pulse must match the oldest expected write.
   always @(negedge clk) begin
      wr_t w;
      if (wb.rf_we === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write at %0t",
                     wb.rf_adrs_w, wb.rf_data_w, $time);
         end else begin
            w = exp_q.pop_front();
            if (w.rd !== wb.rf_adrs_w || w.data !== wb.rf_data_w) begin
               errors++;
               $display("FAIL rf_write: got rd=%0d data=%0h expected rd=%0d data=%0h at %0t",
                        wb.rf_adrs_w, wb.rf_data_w, w.rd, w.data, $time);
            end
         end
      end
   end

   initial begin
      clear_in();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      wb.rs1 = 5'd5;
      #1;
      check("rst_we",    64'(wb.rf_we), 64'd0);
      check("rst_adrs",  64'(wb.rf_adrs_w), 64'd0);
      check("rst_data",  64'(wb.rf_data_w), 64'd0);
      check("rst_ready", 64'(wb.alu_ready), 64'd1);
      check("rst_haz",   64'(wb.hazard), 64'd0);

      // ALU stream: two back-to-back results retire in order
      clear_in();
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_data = 32'hA;
      expect_wr(5'd3, 32'hA);
      step();
      check("t2_first_lat", 64'(wb.rf_we), 64'(BYP));
      wb.alu_rd = 5'd4; wb.alu_data = 32'hB;
      expect_wr(5'd4, 32'hB);
      step();
      wb.alu_valid = 1'b0;
      check("t2_second_we", 64'(wb.rf_we), 64'd1);
      check("t2_second_rd", 64'(wb.rf_adrs_w), BYP ? 64'd4 : 64'd3);
      repeat (2) step();

      // Collision: load return wins over a waiting FIFO head
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd7; wb.alu_data = 32'h11;
      wb.ld_valid = 1'b1; wb.ld_rd = 5'd20; wb.ld_data = 32'h33;
      expect_wr(5'd20, 32'h33);
      step();
      wb.alu_valid = 1'b0;
      wb.ld_rd = 5'd9; wb.ld_data = 32'h22;
      expect_wr(5'd9, 32'h22);
      expect_wr(5'd7, 32'h11);
      check("t3_ld0_rd", 64'(wb.rf_adrs_w), 64'd20);
      step();
      wb.ld_valid = 1'b0;
      check("t3_ld_first", 64'(wb.rf_adrs_w), 64'd9);
      step();
      check("t3_alu_we", 64'(wb.rf_we), 64'd1);
      check("t3_alu_next", 64'(wb.rf_adrs_w), 64'd7);
      step();

      // Backpressure: six load cycles block draining, FIFO fills after four pushes
      for (int i = 0; i < 6; i++) begin
         wb.ld_valid  = 1'b1;
         wb.ld_rd     = 5'(16 + i);
         wb.ld_data   = 32'h100 + 32'(i);
         expect_wr(5'(16 + i), 32'h100 + 32'(i));
         wb.alu_valid = (i < 4);
         wb.alu_rd    = 5'(i + 1);
         wb.alu_data  = 32'h200 + 32'(i);
         wb.rs1       = 5'd2;
         #1;
         check("t4_ready", 64'(wb.alu_ready), 64'(i < 4));
         check("t4_fifo_haz", 64'(wb.hazard), 64'(i >= 2));
         step();
      end
      for (int i = 0; i < 4; i++) expect_wr(5'(i + 1), 32'h200 + 32'(i));
      clear_in();
      wb.rs1 = 5'd2;
      repeat (5) step();
      check("t4_ready_after", 64'(wb.alu_ready), 64'd1);
      check("t4_haz_after", 64'(wb.hazard), 64'd0);

      // Scoreboard
      clear_in();
      wb.ld_issue = 1'b1; wb.ld_issue_rd = 5'd12;
      step();
      wb.ld_issue = 1'b0;
      wb.rs1 = 5'd12;
      #1 check("t5_busy", 64'(wb.hazard), 64'd1);
      repeat (2) step();
      wb.rs1 = 5'd0; wb.rs2 = 5'd12;
      #1 check("t5_busy_rs2", 64'(wb.hazard), 64'd1);
      wb.ld_valid = 1'b1; wb.ld_rd = 5'd12; wb.ld_data = 32'h55;
      expect_wr(5'd12, 32'h55);
      #1 check("t5_ret_cycle", 64'(wb.hazard), 64'd1);
      step();
      wb.ld_valid = 1'b0;
      #1 check("t5_cleared", 64'(wb.hazard), 64'd0);
      wb.ld_issue = 1'b1; wb.ld_issue_rd = 5'd12;
      step();
      wb.ld_valid = 1'b1; wb.ld_rd = 5'd12; wb.ld_data = 32'h66;
      expect_wr(5'd12, 32'h66);
      step();
      wb.ld_issue = 1'b0; wb.ld_valid = 1'b0;
      #1 check("t5_set_wins", 64'(wb.hazard), 64'd1);
      wb.ld_valid = 1'b1; wb.ld_data = 32'h77;
      expect_wr(5'd12, 32'h77);
      step();
      wb.ld_valid = 1'b0;
      #1 check("t5_final_clear", 64'(wb.hazard), 64'd0);

      // x0: never written, never a hazard, FIFO entry still drains
      clear_in();
      wb.ld_valid = 1'b1; wb.ld_rd = 5'd0; wb.ld_data = 32'hDEAD;
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd0; wb.alu_data = 32'hFFFF;
      wb.ld_issue = 1'b1; wb.ld_issue_rd = 5'd0;
      #1 check("t6_haz_x0_ld", 64'(wb.hazard), 64'd0);
      step();
      clear_in();
      check("t6_no_ld_we", 64'(wb.rf_we), 64'd0);
      #1 check("t6_haz_x0_fifo", 64'(wb.hazard), 64'd0);
      step();
      check("t6_no_alu_we", 64'(wb.rf_we), 64'd0);
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_data = 32'h5;
      expect_wr(5'd5, 32'h5);
      step();
      wb.alu_valid = 1'b0;
      check("t6_drain_a", 64'(wb.rf_we), 64'(BYP));
      step();
      check("t6_drain_b", 64'(wb.rf_we), 64'(!BYP));
      step();

      // Async reset mid-cycle with two FIFO entries and busy[5] set
      wb.ld_valid = 1'b1; wb.ld_rd = 5'd25; wb.ld_data = 32'h25;
      wb.ld_issue = 1'b1; wb.ld_issue_rd = 5'd5;
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd10; wb.alu_data = 32'hAA;
      expect_wr(5'd25, 32'h25);
      step();
      wb.ld_issue = 1'b0;
      wb.ld_rd = 5'd26; wb.ld_data = 32'h26;
      wb.alu_rd = 5'd11; wb.alu_data = 32'hBB;
      expect_wr(5'd26, 32'h26);
      step();
      clear_in();
      wb.rs1 = 5'd5;
      #1 check("t1_pre_haz", 64'(wb.hazard), 64'd1);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t1_we",    64'(wb.rf_we), 64'd0);
      check("t1_adrs",  64'(wb.rf_adrs_w), 64'd0);
      check("t1_data",  64'(wb.rf_data_w), 64'd0);
      check("t1_ready", 64'(wb.alu_ready), 64'd1);
      check("t1_haz",   64'(wb.hazard), 64'd0);
      wb.rs1 = 5'd10;
      #1 check("t1_haz_fifo", 64'(wb.hazard), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) step();
      wb.rs1 = 5'd11;
      #1;
      check("t1_post_we", 64'(wb.rf_we), 64'd0);
      check("t1_post_haz", 64'(wb.hazard), 64'd0);

      repeat (2) step();
      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
